color_detect_mul_arbiter: RTL and testbench
===========================================

Name: color_detect_mul_arbiter

Overview:
- Shares one pipelined signed 15x15 multiplier (color_detect_mul_mul_15s_15s_15_4_1, truncating, ce-gated, 3 clock-enabled edges from operand to product) between N_REQ requesters in the color_detect accelerator.
- Grants issue slots round-robin and tracks each in-flight operation's owner tag in a shadow pipeline.
- Returns each product to its owner with valid/ready. Stalls the whole multiplier via ce when the owner is not ready.
- Supports a quiesce/drain handshake so the control FSM can idle the datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 15, operand and product width; must match the multiplier instance.
- MUL_LAT, 3, ce-enabled clock edges from mul_din0/din1 sampled to the product visible on mul_dout.
- TAG_W, $clog2(N_REQ), owner tag width; derived, not overridden.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester grant/accept (one-hot or zero)
- req_a  in  N_REQ*DATA_W  packed signed operand A; slice i belongs to requester i
- req_b  in  N_REQ*DATA_W  packed signed operand B
- rsp_valid  out  N_REQ  product valid for requester i
- rsp_ready  in  N_REQ  requester i accepts its product
- rsp_p  out  DATA_W  product, broadcast to all requesters; qualified by rsp_valid
- mul_ce  out  1  clock enable to the multiplier
- mul_din0  out  DATA_W  multiplier operand A
- mul_din1  out  DATA_W  multiplier operand B
- mul_dout  in  DATA_W  multiplier product
- quiesce  in  1  stop accepting new requests and drain
- idle  out  1  drain complete, no operation in flight
- perf_issue_cnt  out  32  operations issued (see Optional Feature)
- perf_stall_cnt  out  32  cycles with mul_ce=0 (see Optional Feature)

Behaviour:
Reset:
- The reset port is asynchronous and active-high; the clock port is clk.
- All shadow valid bits, tags, the round-robin pointer and the FSM clear asynchronously. FSM goes to RUN, pointer to 0.
- Output reset values: req_ready=0, rsp_valid=0, mul_ce=1, mul_din0=0, mul_din1=0, idle=0.
- Operations in flight at reset are discarded. Multiplier data registers are not reset; the shadow valid bits alone qualify its output.

Shadow pipeline:
- MUL_LAT stages of {vld, tag}. It advances only when mul_ce=1, in lockstep with the multiplier.
- The tail stage aligns with mul_dout.

Stall rule:
- stall = tail_vld & ~rsp_ready[tail_tag]; mul_ce = ~stall. This is combinational.
- While stalled, mul_dout and all shadow stages hold.

Response:
- rsp_valid[i] = tail_vld & (tail_tag==i); rsp_p = mul_dout.
- The transfer completes in a cycle where both rsp_valid[i] and rsp_ready[i] are 1.
- rsp_valid stays asserted and rsp_p stays stable until that transfer.

Issue:
- Allowed only when the FSM is in RUN and mul_ce=1.
- The grant goes to the first i with req_valid[i]=1, searching from pointer upward with wrap.
- That cycle: req_ready[i]=1, mul_din0/din1 take requester i's operands, and the head stage loads vld=1, tag=i.
- Pointer becomes (i+1) mod N_REQ.
- With no grant, mul_din0/din1 are 0 and head vld=0.
- req_ready depends combinationally on req_valid and stall. req_valid must not depend on req_ready.

Latency:
- Unstalled, an operation issued in cycle t shows rsp_valid in cycle t+MUL_LAT.
- Sustained throughput is 1 operation per cycle.

Arithmetic:
- Signed two's complement. The product is the low DATA_W bits of the full product; overflow wraps silently.

FSM:
- RUN: issue enabled. quiesce=1 moves to DRAIN.
- DRAIN: no issue. When all shadow vld bits are 0, move to IDLE.
- IDLE: idle=1, no issue. quiesce=0 moves to RUN.
- If quiesce drops while in DRAIN, return to RUN immediately.
- If quiesce rises in the same cycle as a grant, that grant is still issued and the FSM moves to DRAIN next cycle.

Boundaries:
- Simultaneous tail pop and new issue in the same cycle is legal.
- A stall blocks issue; req_ready stays 0 while stalled.
- N_REQ=1 degenerates to a pass-through with tag 0.

Optional Feature:
- Macro: COLOR_DETECT_MUL_ARB_PERF_EN.
- Defined:
  - perf_issue_cnt increments on every grant.
  - perf_stall_cnt increments on every cycle with mul_ce=0.
  - Both counters are 32-bit, wrap silently, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package color_detect_mul_arb_pkg holds:
  - the FSM state typedef (RUN, DRAIN, IDLE);
  - the shadow stage struct {vld, tag};
  - localparam defaults for DATA_W=15 and MUL_LAT=3.
- Sub-module color_detect_rr_arbiter is natural: a parametric N_REQ round-robin picker with inputs req and pointer, outputs one-hot grant and grant index.

Test Plan:
- Single op: requester 0 sends a=100, b=-3 at cycle 0. Expect req_ready[0]=1 at cycle 0, and rsp_valid[0]=1 with rsp_p=-300 at cycle 3.
- Overflow wrap: a=200, b=200 gives rsp_p=7232. a=-16384, b=2 gives rsp_p=0.
- Fairness: all 4 requesters hold req_valid for 8 cycles. Expect grants in order 0,1,2,3,0,1,2,3 and responses tagged in the same order, one per cycle.
- Backpressure: with the pipeline full, hold rsp_ready[1]=0 for 5 cycles while the tail is requester 1's op. Expect mul_ce=0 and rsp_p stable for those 5 cycles, no new req_ready, and no lost or duplicated responses.
- Drain: assert quiesce with 3 ops in flight. Expect no further grants, all 3 responses delivered, then idle=1. Deassert quiesce; issue resumes the next cycle.
- Reset mid-flight: assert reset with 2 ops in flight. Expect rsp_valid=0 immediately and no stale responses after release; with COLOR_DETECT_MUL_ARB_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/color_detect_mul_arb_pkg.sv
// Shared types and defaults for the color_detect multiplier arbiter.
package color_detect_mul_arb_pkg;

    localparam int DATA_W_DEF  = 15;
    localparam int MUL_LAT_DEF = 3;
    // Wide enough to tag up to 8 requesters.
    localparam int TAG_MAX_W   = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                 vld;
        logic [TAG_MAX_W-1:0] tag;
    } shadow_stage_t;

endpackage

// File: rtl/color_detect_rr_arbiter.sv
// Round-robin picker: first requester at or above ptr wins, wrapping to index 0.
module color_detect_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [TAG_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [TAG_W-1:0] grant_idx,
    output logic             grant_any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && req[i] && (TAG_W'(i) >= ptr)) begin
                grant[i]  = 1'b1;
                grant_idx = TAG_W'(i);
                grant_any = 1'b1;
            end
        end
        // Wrapped pass only runs when nothing at or above ptr was requesting.
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && req[i] && (TAG_W'(i) < ptr)) begin
                grant[i]  = 1'b1;
                grant_idx = TAG_W'(i);
                grant_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/color_detect_mul_arbiter.sv
// Shares one pipelined signed multiplier between N_REQ requesters with owner tags.
// Optional perf counters: define COLOR_DETECT_MUL_ARB_PERF_EN.
module color_detect_mul_arbiter
    import color_detect_mul_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*DATA_W-1:0]  req_a,
    input  logic [N_REQ*DATA_W-1:0]  req_b,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic signed [DATA_W-1:0] rsp_p,
    output logic                     mul_ce,
    output logic signed [DATA_W-1:0] mul_din0,
    output logic signed [DATA_W-1:0] mul_din1,
    input  logic signed [DATA_W-1:0] mul_dout,
    input  logic                     quiesce,
    output logic                     idle,
    output logic [31:0]              perf_issue_cnt,
    output logic [31:0]              perf_stall_cnt
);

    localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state;
    shadow_stage_t    shadow_p [MUL_LAT];
    shadow_stage_t    tail;
    logic [TAG_W-1:0] ptr;
    logic [N_REQ-1:0] grant;
    logic [TAG_W-1:0] grant_idx;
    logic             grant_any;
    logic             stall;
    logic             issue_en;
    logic             issue;
    logic             any_vld;

    assign tail = shadow_p[MUL_LAT-1];

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = tail.vld && (tail.tag == TAG_MAX_W'(i));
        end
    end

    assign stall  = |(rsp_valid & ~rsp_ready);
    assign mul_ce = ~stall;
    assign rsp_p  = mul_dout;

    // Issue is held off while reset is asserted so req_ready reads 0 during reset.
    assign issue_en = (state == RUN) && mul_ce && !reset;

    color_detect_rr_arbiter #(
        .N_REQ (N_REQ),
        .TAG_W (TAG_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign issue     = issue_en && grant_any;
    assign req_ready = issue ? grant : '0;

    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (issue && grant[i]) begin
                mul_din0 = $signed(req_a[i*DATA_W +: DATA_W]);
                mul_din1 = $signed(req_b[i*DATA_W +: DATA_W]);
            end
        end
    end

    always_comb begin
        any_vld = 1'b0;
        for (int k = 0; k < MUL_LAT; k++) begin
            any_vld = any_vld | shadow_p[k].vld;
        end
    end

    // Shadow stages p0..p(MUL_LAT-1) move in lockstep with the multiplier's ce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                shadow_p[k] <= '0;
            end
        end else if (mul_ce) begin
            shadow_p[0].vld <= issue;
            shadow_p[0].tag <= TAG_MAX_W'(grant_idx);
            for (int k = 1; k < MUL_LAT; k++) begin
                shadow_p[k] <= shadow_p[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            idle  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (quiesce) state <= DRAIN;
                end
                DRAIN: begin
                    if (!quiesce) begin
                        state <= RUN;
                    end else if (!any_vld) begin
                        state <= IDLE;
                        idle  <= 1'b1;
                    end
                end
                IDLE: begin
                    if (!quiesce) begin
                        state <= RUN;
                        idle  <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                    idle  <= 1'b0;
                end
            endcase
        end
    end

`ifdef COLOR_DETECT_MUL_ARB_PERF_EN
    logic [31:0] issue_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (issue)   issue_cnt <= issue_cnt + 32'd1;
            if (!mul_ce) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_issue_cnt = issue_cnt;
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_issue_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_color_detect_mul_arbiter.sv
// Directed bench for color_detect_mul_arbiter with a 3-stage truncating multiplier model.
module tb_color_detect_mul_arbiter;

    localparam int N  = 4;
    localparam int DW = 15;

`ifdef COLOR_DETECT_MUL_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                 clk;
    logic                 reset;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N*DW-1:0]      req_a;
    logic [N*DW-1:0]      req_b;
    logic [N-1:0]         rsp_valid;
    logic [N-1:0]         rsp_ready;
    logic signed [DW-1:0] rsp_p;
    logic                 mul_ce;
    logic signed [DW-1:0] mul_din0;
    logic signed [DW-1:0] mul_din1;
    logic signed [DW-1:0] mul_dout;
    logic                 quiesce;
    logic                 idle;
    logic [31:0]          perf_issue_cnt;
    logic [31:0]          perf_stall_cnt;

    int checks   = 0;
    int failures = 0;

    color_detect_mul_arbiter #(.N_REQ(N), .DATA_W(DW), .MUL_LAT(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_p          (rsp_p),
        .mul_ce         (mul_ce),
        .mul_din0       (mul_din0),
        .mul_din1       (mul_din1),
        .mul_dout       (mul_dout),
        .quiesce        (quiesce),
        .idle           (idle),
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: full signed product truncated to DW bits, three ce-gated stages.
    logic signed [2*DW-1:0] full_prod;
    logic signed [DW-1:0]   m_p0, m_p1, m_p2;
    assign full_prod = mul_din0 * mul_din1;
    always @(posedge clk) begin
        if (mul_ce) begin
            m_p0 <= full_prod[DW-1:0];
            m_p1 <= m_p0;
            m_p2 <= m_p1;
        end
    end
    assign mul_dout = m_p2;

    function automatic logic [31:0] p15(input int v);
        logic [31:0] r;
        r = 32'(v);
        return {17'b0, r[14:0]};
    endfunction

    function automatic logic [31:0] u15(input logic [14:0] x);
        return {17'b0, x};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        logic [31:0] av, bv;
        av = 32'(a);
        bv = 32'(b);
        req_a[i*DW +: DW] = av[DW-1:0];
        req_b[i*DW +: DW] = bv[DW-1:0];
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] bp_rdy [14] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] bp_rv  [14] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0};
    int         bp_p   [14] = '{0, 0, 0, 10, 20, 20, 20, 20, 20, 20, 30, 40, 10, 0};

    logic [3:0] dr_rdy [11] = '{4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h0};
    logic [3:0] dr_rv  [11] = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    int         dr_p   [11] = '{0, 0, 0, -30, -45, -60, 0, 0, 0, 0, 0};
    logic       dr_idle[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        quiesce   = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mul_ce",    32'(mul_ce),    32'd1);
        chk("rst_din0",      u15(mul_din0),  32'd0);
        chk("rst_din1",      u15(mul_din1),  32'd0);
        chk("rst_idle",      32'(idle),      32'd0);
        req_valid = '0;
        reset     = 1'b0;

        // Single operation: 100 * -3
        set_op(0, 100, -3);
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready), 32'd1);
        chk("t1_din0",  u15(mul_din0),  p15(100));
        chk("t1_din1",  u15(mul_din1),  p15(-3));
        next_cycle();
        req_valid = '0;
        #1;
        chk("t1_rv_c1", 32'(rsp_valid), 32'd0);
        next_cycle();
        #1;
        chk("t1_rv_c2", 32'(rsp_valid), 32'd0);
        next_cycle();
        #1;
        chk("t1_rv_c3", 32'(rsp_valid), 32'd1);
        chk("t1_p",     u15(rsp_p),     p15(-300));
        next_cycle();

        // Overflow wrap from requesters 2 and 3; pointer ends at 0
        set_op(2, 200, 200);
        req_valid = 4'b0100;
        #1;
        chk("t2_ready_a", 32'(req_ready), 32'h4);
        next_cycle();
        set_op(3, -16384, 2);
        req_valid = 4'b1000;
        #1;
        chk("t2_ready_b", 32'(req_ready), 32'h8);
        next_cycle();
        req_valid = '0;
        #1;
        chk("t2_rv_c2", 32'(rsp_valid), 32'd0);
        next_cycle();
        #1;
        chk("t2_rv_a", 32'(rsp_valid), 32'h4);
        chk("t2_p_a",  u15(rsp_p),     p15(7232));
        next_cycle();
        #1;
        chk("t2_rv_b", 32'(rsp_valid), 32'h8);
        chk("t2_p_b",  u15(rsp_p),     p15(0));
        next_cycle();

        // Fairness: all four requesters valid for 8 cycles
        for (int i = 0; i < N; i++) set_op(i, i + 1, 10);
        for (int c = 0; c < 11; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            chk($sformatf("t3_ready_c%0d", c), 32'(req_ready), (c < 8) ? (32'd1 << (c % 4)) : 32'd0);
            if (c >= 3) begin
                chk($sformatf("t3_rv_c%0d", c), 32'(rsp_valid), 32'd1 << ((c - 3) % 4));
                chk($sformatf("t3_p_c%0d", c),  u15(rsp_p),     p15(((c - 3) % 4 + 1) * 10));
            end else begin
                chk($sformatf("t3_rv_c%0d", c), 32'(rsp_valid), 32'd0);
            end
            next_cycle();
        end

        // Backpressure: requester 1 refuses its product for 5 cycles
        for (int c = 0; c < 14; c++) begin
            req_valid = (c <= 9) ? 4'hF : 4'h0;
            rsp_ready = (c <= 8) ? 4'b1101 : 4'b1111;
            #1;
            chk($sformatf("t4_ready_c%0d", c), 32'(req_ready), 32'(bp_rdy[c]));
            chk($sformatf("t4_rv_c%0d", c),    32'(rsp_valid), 32'(bp_rv[c]));
            chk($sformatf("t4_ce_c%0d", c),    32'(mul_ce),    (c >= 4 && c <= 8) ? 32'd0 : 32'd1);
            if (bp_rv[c] != 4'h0) chk($sformatf("t4_p_c%0d", c), u15(rsp_p), p15(bp_p[c]));
            next_cycle();
        end
        #1;
        chk("t4_perf_issue", perf_issue_cnt, PERF ? 32'd16 : 32'd0);
        chk("t4_perf_stall", perf_stall_cnt, PERF ? 32'd5  : 32'd0);

        // Drain: quiesce rises with the third grant, then idle, then resume
        for (int i = 0; i < N; i++) set_op(i, (i + 1) * 3, -5);
        for (int c = 0; c < 11; c++) begin
            req_valid = (c <= 9) ? 4'hF : 4'h0;
            quiesce   = (c >= 2 && c <= 6);
            #1;
            chk($sformatf("t5_ready_c%0d", c), 32'(req_ready), 32'(dr_rdy[c]));
            chk($sformatf("t5_rv_c%0d", c),    32'(rsp_valid), 32'(dr_rv[c]));
            chk($sformatf("t5_idle_c%0d", c),  32'(idle),      32'(dr_idle[c]));
            if (dr_rv[c] != 4'h0) chk($sformatf("t5_p_c%0d", c), u15(rsp_p), p15(dr_p[c]));
            next_cycle();
        end

        // Reset with two operations in flight, tail about to present
        reset     = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("t6_rv",         32'(rsp_valid), 32'd0);
        chk("t6_ready",      32'(req_ready), 32'd0);
        chk("t6_ce",         32'(mul_ce),    32'd1);
        chk("t6_idle",       32'(idle),      32'd0);
        chk("t6_perf_issue", perf_issue_cnt, 32'd0);
        chk("t6_perf_stall", perf_stall_cnt, 32'd0);
        next_cycle();
        next_cycle();
        reset     = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("t6_stale_c%0d", c), 32'(rsp_valid), 32'd0);
            next_cycle();
        end

        // Recovery after reset: pointer back at 0, lone requester 2
        set_op(2, 7, 6);
        req_valid = 4'b0100;
        #1;
        chk("t7_ready", 32'(req_ready), 32'h4);
        next_cycle();
        req_valid = '0;
        next_cycle();
        next_cycle();
        #1;
        chk("t7_rv", 32'(rsp_valid), 32'h4);
        chk("t7_p",  u15(rsp_p),     p15(42));
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
